// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: host-transmit FSM encoding, frame geometry and line filter depth.
package ps2_pkg;

    typedef enum logic [2:0] {
        ST_IDLE         = 3'd0,
        ST_INHIBIT      = 3'd1,
        ST_RTS          = 3'd2,
        ST_SHIFT        = 3'd3,
        ST_ACK          = 3'd4,
        ST_RELEASE_WAIT = 3'd5
    } ps2_tx_state_e;

    // start + 8 data + parity + stop
    localparam int FRAME_LEN    = 11;
    localparam int FILTER_DEPTH = 8;

    typedef struct packed {
        ps2_tx_state_e state;
        logic [3:0]    bit_cnt;
        logic          clk_level;
        logic          data_level;
        logic          clk_fall;
        logic          data_fall;
    } ps2_tx_dbg_t;

    function automatic logic odd_parity(input logic [7:0] d);
        return ~^d;
    endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// Synchronizes one raw PS/2 line, accepts a new level only after FILTER_DEPTH stable cycles,
// and strobes fall_o in the cycle the filtered level goes low.
module ps2_line_filter
    import ps2_pkg::*;
(
    input  logic clk_i,
    input  logic rst_i,
    input  logic line_i,
    output logic level_o,
    output logic fall_o
);

    localparam int CNT_W = $clog2(FILTER_DEPTH);

    logic [1:0]       sync_q;
    logic             level_q, level_d;
    logic             fall_q, fall_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        level_d = level_q;
        fall_d  = 1'b0;
        cnt_d   = '0;
        if (sync_q[1] != level_q) begin
            if (cnt_q == CNT_W'(FILTER_DEPTH - 1)) begin
                level_d = sync_q[1];
                fall_d  = ~sync_q[1];
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync_q  <= 2'b11;
            level_q <= 1'b1;
            fall_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync_q  <= {sync_q[0], line_i};
            level_q <= level_d;
            fall_q  <= fall_d;
            cnt_q   <= cnt_d;
        end
    end

    assign level_o = level_q;
    assign fall_o  = fall_q;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device byte transmitter: inhibit, request-to-send, shift on device clock falls,
// check the device acknowledge, then wait for both lines to be released.
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int CLK_HZ     = 50_000_000,
    parameter int INHIBIT_US = 120,
    parameter int TIMEOUT_MS = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  tx_data,
    input  logic        tx_start,
    input  logic        ps2_clk_in,
    input  logic        ps2_data_in,
    output logic        ps2_clk_oe,
    output logic        ps2_data_oe,
    output logic        tx_busy,
    output logic        tx_done,
    output logic        tx_err,
    output ps2_tx_dbg_t dbg_o
);

    localparam int INHIBIT_CYCLES = CLK_HZ / 1_000_000 * INHIBIT_US;
    localparam int TIMEOUT_CYCLES = CLK_HZ / 1000 * TIMEOUT_MS;
    localparam int INH_W  = $clog2(INHIBIT_CYCLES + 1);
    localparam int TOUT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam int REL_W  = $clog2(FILTER_DEPTH);
    localparam logic [INH_W-1:0]  INH_LAST  = INH_W'(INHIBIT_CYCLES - 1);
    localparam logic [TOUT_W-1:0] TOUT_LAST = TOUT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [REL_W-1:0]  REL_LAST  = REL_W'(FILTER_DEPTH - 1);
    localparam logic [3:0]        LAST_BIT  = 4'(FRAME_LEN - 2);

    ps2_tx_state_e     state_q, state_d;
    logic [7:0]        data_q, data_d;
    logic              parity_q, parity_d;
    logic [3:0]        bit_cnt_q, bit_cnt_d;
    logic [INH_W-1:0]  inh_cnt_q, inh_cnt_d;
    logic [TOUT_W-1:0] tout_cnt_q, tout_cnt_d;
    logic [REL_W-1:0]  rel_cnt_q, rel_cnt_d;
    logic              data_oe_q, data_oe_d;
    logic              err_flag_q, err_flag_d;

    logic clk_f, clk_fall, data_f, data_fall;
    logic expire, frame_bit, released;

    ps2_line_filter u_clk_filter (
        .clk_i  (clk),
        .rst_i  (rst),
        .line_i (ps2_clk_in),
        .level_o(clk_f),
        .fall_o (clk_fall)
    );

    ps2_line_filter u_data_filter (
        .clk_i  (clk),
        .rst_i  (rst),
        .line_i (ps2_data_in),
        .level_o(data_f),
        .fall_o (data_fall)
    );

    assign expire    = (tout_cnt_q == TOUT_LAST);
    assign released  = clk_f && data_f;
    // Frame index 0..7 = data LSB first, 8 = parity, 9 = stop
    assign frame_bit = (bit_cnt_q < 4'd8)  ? data_q[bit_cnt_q[2:0]] :
                       (bit_cnt_q == 4'd8) ? parity_q : 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            data_q     <= '0;
            parity_q   <= 1'b0;
            bit_cnt_q  <= '0;
            inh_cnt_q  <= '0;
            tout_cnt_q <= '0;
            rel_cnt_q  <= '0;
            data_oe_q  <= 1'b0;
            err_flag_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            data_q     <= data_d;
            parity_q   <= parity_d;
            bit_cnt_q  <= bit_cnt_d;
            inh_cnt_q  <= inh_cnt_d;
            tout_cnt_q <= tout_cnt_d;
            rel_cnt_q  <= rel_cnt_d;
            data_oe_q  <= data_oe_d;
            err_flag_q <= err_flag_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        data_d     = data_q;
        parity_d   = parity_q;
        bit_cnt_d  = bit_cnt_q;
        inh_cnt_d  = '0;
        tout_cnt_d = '0;
        rel_cnt_d  = '0;
        data_oe_d  = data_oe_q;
        err_flag_d = err_flag_q;
        unique case (state_q)
            ST_IDLE: begin
                if (tx_start) begin
                    data_d     = tx_data;
                    parity_d   = odd_parity(tx_data);
                    bit_cnt_d  = '0;
                    err_flag_d = 1'b0;
                    data_oe_d  = 1'b1;
                    state_d    = ST_INHIBIT;
                end
            end
            ST_INHIBIT: begin
                if (inh_cnt_q == INH_LAST) state_d = ST_RTS;
                else                       inh_cnt_d = inh_cnt_q + 1'b1;
            end
            ST_RTS: begin
                if (expire) begin
                    err_flag_d = 1'b1;
                    state_d    = ST_RELEASE_WAIT;
                end else begin
                    tout_cnt_d = tout_cnt_q + 1'b1;
                    if (clk_fall) begin
                        bit_cnt_d = '0;
                        state_d   = ST_SHIFT;
                    end
                end
            end
            ST_SHIFT: begin
                if (expire) begin
                    err_flag_d = 1'b1;
                    state_d    = ST_RELEASE_WAIT;
                end else begin
                    tout_cnt_d = tout_cnt_q + 1'b1;
                    if (clk_fall) begin
                        data_oe_d = ~frame_bit;
                        if (bit_cnt_q == LAST_BIT) state_d = ST_ACK;
                        else                       bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
            end
            ST_ACK: begin
                if (expire) begin
                    err_flag_d = 1'b1;
                    state_d    = ST_RELEASE_WAIT;
                end else begin
                    tout_cnt_d = tout_cnt_q + 1'b1;
                    if (clk_fall) begin
                        err_flag_d = data_f;
                        state_d    = ST_RELEASE_WAIT;
                    end
                end
            end
            ST_RELEASE_WAIT: begin
                if (released) begin
                    if (rel_cnt_q == REL_LAST) state_d = ST_IDLE;
                    else                       rel_cnt_d = rel_cnt_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Pulses are masked under reset so an aborted transfer never reports completion
    always_comb begin
        ps2_clk_oe  = 1'b0;
        ps2_data_oe = 1'b0;
        tx_done     = 1'b0;
        tx_err      = 1'b0;
        tx_busy     = (state_q != ST_IDLE);
        unique case (state_q)
            ST_INHIBIT: begin
                ps2_clk_oe  = 1'b1;
                ps2_data_oe = (inh_cnt_q == INH_LAST);
            end
            ST_RTS: begin
                ps2_data_oe = ~expire;
                tx_err      = expire & ~rst;
            end
            ST_SHIFT: begin
                ps2_data_oe = data_oe_q & ~expire;
                tx_err      = expire & ~rst;
            end
            ST_ACK: begin
                tx_err = (expire | (clk_fall & data_f)) & ~rst;
            end
            ST_RELEASE_WAIT: begin
                tx_done = released & (rel_cnt_q == REL_LAST) & ~err_flag_q & ~rst;
            end
            default: ;
        endcase
    end

    assign dbg_o = '{state:      state_q,
                     bit_cnt:    bit_cnt_q,
                     clk_level:  clk_f,
                     data_level: data_f,
                     clk_fall:   clk_fall,
                     data_fall:  data_fall};

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: a PS/2 device model clocks frames out of a scaled-down instance,
// and a default-parameter instance is used for the 50 MHz inhibit length.
module tb_ps2_host_tx;
    import ps2_pkg::*;

    localparam int INH_CYC  = 240;   // 2 MHz * 120 us
    localparam int TOUT_CYC = 2000;  // 2 MHz * 1 ms
    localparam int INH50    = 6000;  // 50 MHz * 120 us
    localparam int H        = 20;    // device half clock period, in system cycles

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  tx_data = 8'h00;
    logic        tx_start = 1'b0;
    logic        dev_clk_low = 1'b0;
    logic        dev_data_low = 1'b0;
    logic        ps2_clk_oe, ps2_data_oe, tx_busy, tx_done, tx_err;
    logic        clk_line, data_line;
    ps2_tx_dbg_t dbg;

    logic        tx_start50 = 1'b0;
    logic        clk_oe50, data_oe50, busy50, done50, err50;
    ps2_tx_dbg_t dbg50;

    int checks = 0;
    int failures = 0;
    int done_cnt = 0;
    int err_cnt = 0;

    typedef struct {
        logic [7:0] data;
        logic       ack_low;
        logic       poke;
        logic [9:0] exp_frame;  // {stop, parity, data[7:0]} as sampled by the device
        int         exp_done;
        int         exp_err;
    } vec_t;

    vec_t vecs[6];

    always #5 clk = ~clk;

    assign clk_line  = !ps2_clk_oe && !dev_clk_low;
    assign data_line = !ps2_data_oe && !dev_data_low;

    ps2_host_tx #(.CLK_HZ(2_000_000), .INHIBIT_US(120), .TIMEOUT_MS(1)) dut (
        .clk(clk), .rst(rst), .tx_data(tx_data), .tx_start(tx_start),
        .ps2_clk_in(clk_line), .ps2_data_in(data_line),
        .ps2_clk_oe(ps2_clk_oe), .ps2_data_oe(ps2_data_oe),
        .tx_busy(tx_busy), .tx_done(tx_done), .tx_err(tx_err), .dbg_o(dbg)
    );

    ps2_host_tx dut50 (
        .clk(clk), .rst(rst), .tx_data(8'hF3), .tx_start(tx_start50),
        .ps2_clk_in(1'b1), .ps2_data_in(1'b1),
        .ps2_clk_oe(clk_oe50), .ps2_data_oe(data_oe50),
        .tx_busy(busy50), .tx_done(done50), .tx_err(err50), .dbg_o(dbg50)
    );

    always @(posedge clk) begin
        if (tx_done) done_cnt <= done_cnt + 1;
        if (tx_err)  err_cnt  <= err_cnt + 1;
    end

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic start_tx(input logic [7:0] d);
        tx_data  = d;
        tx_start = 1'b1;
        tick(1);
        tx_start = 1'b0;
    endtask

    // Returns at the first RTS cycle; counts inhibit cycles and where the start bit appeared
    task automatic wait_rts(output int inh, output int dlow_at);
        int guard;
        inh = 0; dlow_at = -1; guard = 0;
        while (!(ps2_clk_oe == 1'b0 && ps2_data_oe == 1'b1) && guard < INH_CYC + 100) begin
            if (ps2_clk_oe) inh++;
            if (ps2_clk_oe && ps2_data_oe && dlow_at < 0) dlow_at = inh;
            tick(1);
            guard++;
        end
        check("rts_reached", (guard < INH_CYC + 100), 1);
    endtask

    task automatic wait_idle();
        int guard;
        guard = 0;
        while (tx_busy && guard < 400) begin
            tick(1);
            guard++;
        end
        check("idle_reached", (guard < 400), 1);
    endtask

    task automatic apply_vec(input vec_t v);
        int inh, dlow_at, d0, e0;
        logic [10:0] smp;
        d0 = done_cnt; e0 = err_cnt;
        start_tx(v.data);
        check("busy_after_start", tx_busy, 1);
        wait_rts(inh, dlow_at);
        check("inhibit_len", inh, INH_CYC);
        check("start_bit_at", dlow_at, INH_CYC);
        tick(10);
        for (int p = 0; p < 11; p++) begin
            dev_clk_low = 1'b1;
            if (v.poke && p == 4) begin
                tx_data  = 8'h00;
                tx_start = 1'b1;
                tick(1);
                tx_start = 1'b0;
                tick(H - 1);
            end else begin
                tick(H);
            end
            dev_clk_low = 1'b0;
            smp[p] = data_line;
            tick(H);
        end
        dev_data_low = v.ack_low;
        tick(H);
        dev_clk_low = 1'b1;
        tick(H);
        dev_clk_low = 1'b0;
        tick(H / 2);
        dev_data_low = 1'b0;
        wait_idle();
        check("start_bit", smp[0], 0);
        check("frame_bits", smp[10:1], v.exp_frame);
        check("done_count", done_cnt - d0, v.exp_done);
        check("err_count", err_cnt - e0, v.exp_err);
        check("lines_released", {ps2_clk_oe, ps2_data_oe}, 2'b00);
        check("state_idle", dbg.state, ST_IDLE);
        if (v.poke) begin
            tick(30);
            check("poke_ignored_busy", tx_busy, 0);
        end
    endtask

    initial begin
        int inh, dlow_at, n, d0, e0, guard;
        vec_t v;

        vecs[0] = '{data: 8'hF3, ack_low: 1'b1, poke: 1'b0, exp_frame: 10'h3F3, exp_done: 1, exp_err: 0};
        vecs[1] = '{data: 8'h07, ack_low: 1'b1, poke: 1'b0, exp_frame: 10'h207, exp_done: 1, exp_err: 0};
        vecs[2] = '{data: 8'h00, ack_low: 1'b1, poke: 1'b0, exp_frame: 10'h300, exp_done: 1, exp_err: 0};
        vecs[3] = '{data: 8'hA5, ack_low: 1'b0, poke: 1'b1, exp_frame: 10'h3A5, exp_done: 0, exp_err: 1};
        vecs[4] = '{data: 8'h80, ack_low: 1'b1, poke: 1'b0, exp_frame: 10'h280, exp_done: 1, exp_err: 0};
        vecs[5] = '{data: 8'hFF, ack_low: 1'b1, poke: 1'b0, exp_frame: 10'h3FF, exp_done: 1, exp_err: 0};

        rst = 1'b1;
        tick(4);
        check("rst_clk_oe", ps2_clk_oe, 0);
        check("rst_data_oe", ps2_data_oe, 0);
        check("rst_busy", tx_busy, 0);
        check("rst_done_err", {tx_done, tx_err}, 2'b00);
        check("rst_state", dbg.state, ST_IDLE);
        check("rst_filters", {dbg.clk_level, dbg.data_level}, 2'b11);
        rst = 1'b0;
        tick(2);

        // Default-parameter instance: inhibit length at 50 MHz
        tx_start50 = 1'b1;
        tick(1);
        tx_start50 = 1'b0;
        inh = 0; dlow_at = -1; guard = 0;
        while (!(clk_oe50 == 1'b0 && data_oe50 == 1'b1) && guard < INH50 + 100) begin
            if (clk_oe50) inh++;
            if (clk_oe50 && data_oe50 && dlow_at < 0) dlow_at = inh;
            tick(1);
            guard++;
        end
        check("inhibit50_len", inh, INH50);
        check("inhibit50_start_bit_at", dlow_at, INH50);

        for (int i = 0; i < 6; i++) apply_vec(vecs[i]);

        // Device never clocks: timeout from the first RTS cycle
        d0 = done_cnt; e0 = err_cnt;
        start_tx(8'h55);
        wait_rts(inh, dlow_at);
        n = 0;
        while (!tx_err && n < TOUT_CYC + 500) begin
            tick(1);
            n++;
        end
        check("timeout_cycles", n, TOUT_CYC - 1);
        check("timeout_lines", {ps2_clk_oe, ps2_data_oe}, 2'b00);
        wait_idle();
        check("timeout_done", done_cnt - d0, 0);
        check("timeout_err", err_cnt - e0, 1);

        // Reset after shift edge 5 of 0x0F (data[4]=0 so data is being pulled low)
        d0 = done_cnt; e0 = err_cnt;
        start_tx(8'h0F);
        wait_rts(inh, dlow_at);
        tick(10);
        for (int p = 0; p < 6; p++) begin
            dev_clk_low = 1'b1;
            tick(H);
            if (p < 5) begin
                dev_clk_low = 1'b0;
                tick(H);
            end
        end
        check("pre_rst_data_oe", ps2_data_oe, 1);
        check("pre_rst_busy", tx_busy, 1);
        rst = 1'b1;
        tick(1);
        check("rst_mid_lines", {ps2_clk_oe, ps2_data_oe}, 2'b00);
        check("rst_mid_busy", tx_busy, 0);
        rst = 1'b0;
        dev_clk_low = 1'b0;
        tick(30);
        check("rst_mid_done", done_cnt - d0, 0);
        check("rst_mid_err", err_cnt - e0, 0);
        check("rst_mid_idle_busy", tx_busy, 0);

        v = '{data: 8'hFF, ack_low: 1'b1, poke: 1'b0, exp_frame: 10'h3FF, exp_done: 1, exp_err: 0};
        apply_vec(v);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ps2_host_tx.md
PS2_HOST_TX -- requirements
Module: ps2_host_tx

Interface
REQ-001 Parameter CLK_HZ, default 50_000_000, system clock frequency in Hz.
REQ-002 Parameter INHIBIT_US, default 120, minimum time in microseconds that ps2_clk is held low before the request-to-send.
REQ-003 Parameter TIMEOUT_MS, default 15, maximum time in milliseconds from the request-to-send until the acknowledge.
REQ-004 clk  in  1  single system clock; all logic is on the rising edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 tx_data  in  8  command byte to send to the scanner; captured when tx_start is accepted.
REQ-007 tx_start  in  1  one-cycle request to transmit tx_data.
REQ-008 ps2_clk_in  in  1  raw, asynchronous PS/2 clock line sense.
REQ-009 ps2_data_in  in  1  raw, asynchronous PS/2 data line sense.
REQ-010 ps2_clk_oe  out  1  1 pulls the open-drain PS/2 clock line low.
REQ-011 ps2_data_oe  out  1  1 pulls the open-drain PS/2 data line low.
REQ-012 tx_busy  out  1  high from the accepted tx_start until return to IDLE; also serves as the receive-inhibit for ps2_top.
REQ-013 tx_done  out  1  one-cycle pulse: byte acknowledged by the device.
REQ-014 tx_err  out  1  one-cycle pulse: timeout or missing acknowledge.

Function
REQ-015 Both PS/2 inputs SHALL pass through a 2-flop synchronizer and an 8-cycle stable-level filter; fall_edge is a one-cycle strobe taken on the filtered clock.
REQ-016 The FSM states SHALL be IDLE, INHIBIT, RTS, SHIFT, ACK, RELEASE_WAIT.
REQ-017 IDLE: tx_start=1 latches tx_data, computes odd parity (parity = ~^tx_data), sets tx_busy, and moves to INHIBIT on the next cycle.
REQ-018 tx_start arriving while tx_busy=1 SHALL be ignored with no error indication.
REQ-019 INHIBIT: ps2_clk_oe=1, ps2_data_oe=0, for exactly CLK_HZ/1_000_000*INHIBIT_US cycles.
REQ-020 INHIBIT: in the last cycle, ps2_data_oe is set to 1 (start bit); the next state is RTS.
REQ-021 RTS: ps2_clk_oe=0 and ps2_data_oe=1; the timeout counter starts; the first fall_edge moves the FSM to SHIFT with bit index 0.
REQ-022 SHIFT: on each fall_edge, ps2_data_oe is driven with the inverse of the current frame bit.
REQ-023 SHIFT frame bit order: data[0..7] on edges 1-8, parity on edge 9, stop (oe=0) on edge 10.
REQ-024 After edge 10 the FSM SHALL go to ACK.
REQ-025 ACK: on the next fall_edge, filtered data=0 moves the FSM to RELEASE_WAIT; data=1 pulses tx_err and moves to RELEASE_WAIT.
REQ-026 RELEASE_WAIT: wait until filtered clk=1 and data=1 for 8 consecutive cycles.
REQ-027 RELEASE_WAIT exit: pulse tx_done (if no error was flagged), clear tx_busy, and return to IDLE.
REQ-028 Timeout counter width SHALL be $clog2(CLK_HZ/1000*TIMEOUT_MS+1).
REQ-029 On expiry in RTS, SHIFT, or ACK: pulse tx_err, drop both oe outputs in the same cycle, and go to RELEASE_WAIT.
REQ-030 tx_done and tx_err SHALL never be asserted in the same transfer.
REQ-031 Frame bit counter is 4 bits and SHALL not wrap; values greater than 10 are unreachable.
REQ-032 Outside INHIBIT, RTS, and SHIFT, both oe outputs SHALL be 0.

Reset
REQ-033 rst=1 SHALL force the following on the next clk edge: state IDLE, ps2_clk_oe=0, ps2_data_oe=0, tx_busy=0, tx_done=0, tx_err=0, counters 0, filters preset to 1.
REQ-034 rst asserted mid-transfer SHALL release both lines within one cycle and produce no tx_done or tx_err pulse.

Structure
REQ-035 The state encoding, the frame length constant (11), and the filter depth (8) SHALL live in the shared package ps2_pkg, which ps2_top also uses.
REQ-036 Synchronizer plus filter plus edge detect SHALL be one sub-module, ps2_line_filter, instantiated twice (clk, data).

Verification
REQ-037 Scenario: tx_data=0xF3 with a device model clocking at 12.5 kHz -> data bits 1,1,0,0,1,1,1,1, parity 1, stop, ack low -> one tx_done, tx_busy low afterwards.
REQ-038 Scenario: tx_data=0x07 -> parity bit sampled 0; tx_data=0x00 -> parity bit sampled 1.
REQ-039 Scenario: INHIBIT_US=120 at 50 MHz -> ps2_clk_oe high for exactly 6000 cycles before data goes low.
REQ-040 Scenario: device never clocks -> tx_err after TIMEOUT_MS (750000 cycles from RTS), lines released, no tx_done.
REQ-041 Scenario: device leaves data high at the ack edge -> tx_err once; second tx_start during busy ignored.
REQ-042 Scenario: rst pulsed after edge 5 -> both oe=0 next cycle, tx_busy=0, no done/err pulse; a new 0xFF transfer then completes normally.
